// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus a WIDTH-cycle restoring divider,
// valid/ready on both sides, and the eq/gt flag register read by branches.
module execute_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_signal,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq_flag,
  output logic             gt_flag,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_LD  = 5'd14;
  localparam logic [4:0] OP_ST  = 5'd15;

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_mod_q, is_mod_d;

  logic             accept;
  logic             is_divmod;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_divmod = (alu_signal == OP_DIV) || (alu_signal == OP_MOD);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign eq_flag   = eq_q;
  assign gt_flag   = gt_q;
  assign busy      = (state_q == S_DIV);

  // Single-cycle datapath; div/mod here only cover the divide-by-zero case.
  always_comb begin
    alu_res = '0;
    case (alu_signal)
      OP_ADD, OP_LD, OP_ST: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_MUL: alu_res = op_a * op_b;
      OP_DIV: alu_res = '0;
      OP_MOD: alu_res = op_a;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_NOT: alu_res = ~op_b;
      OP_MOV: alu_res = op_b;
      OP_LSL: alu_res = op_a << op_b[SHW-1:0];
      OP_LSR: alu_res = op_a >> op_b[SHW-1:0];
      OP_ASR: alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      default: alu_res = '0;
    endcase
  end

  // One restoring shift-subtract step plus sign fix-up of the step's outcome.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fix = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix = neg_rem_q ? -rem_nx : rem_nx;
  end

  // Next-state, handshake, flag and divider-load logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    is_mod_d    = is_mod_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_divmod && (op_b != '0)) begin
            state_d   = S_DIV;
            quo_d     = op_a[WIDTH-1] ? -op_a : op_a;
            dvs_d     = op_b[WIDTH-1] ? -op_b : op_b;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem_d = op_a[WIDTH-1];
            is_mod_d  = (alu_signal == OP_MOD);
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            if (alu_signal == OP_CMP) begin
              eq_d = (op_a == op_b);
              gt_d = ($signed(op_a) > $signed(op_b));
            end
          end
        end
      end
      S_DIV: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          result_d    = is_mod_q ? rem_fix : quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any divide in flight and clears flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_mod_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      is_mod_q    <= is_mod_d;
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: expected results are queued on accept
// and compared (with latency, hold and flag checks) when the unit responds.
module tb_execute_unit;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   alu_signal;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         eq_flag;
  logic         gt_flag;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         eq;
    logic         gt;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   head_seen = 1'b0;
  logic m_eq = 1'b0;
  logic m_gt = 1'b0;

  execute_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_signal(alu_signal), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .eq_flag(eq_flag), .gt_flag(gt_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference results from native signed arithmetic with the corner cases spelled out.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      5'd0, 5'd14, 5'd15: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a * b;
      5'd3: begin
        if (b == '0) r = '0;
        else if (a == MINV && b == '1) r = MINV;
        else r = $signed(a) / $signed(b);
      end
      5'd4: begin
        if (b == '0) r = a;
        else if (a == MINV && b == '1) r = '0;
        else r = $signed(a) % $signed(b);
      end
      5'd6: r = a & b;
      5'd7: r = a | b;
      5'd8: r = ~b;
      5'd9: r = b;
      5'd10: r = a << b[4:0];
      5'd11: r = a >> b[4:0];
      5'd12: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: compare outputs, then enqueue the op accepted this cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      head_seen = 1'b0;
      m_eq = 1'b0;
      m_gt = 1'b0;
    end else begin
      if (sb.size() > 0 && !out_valid && sb[0].lat > 1) begin
        check("busy_div", 64'(busy), 64'(1));
        check("in_ready_div", 64'(in_ready), 64'(0));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          if (!head_seen) begin
            check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            check("busy_done", 64'(busy), 64'(0));
            head_seen = 1'b1;
          end
          if (!out_ready) check("in_ready_hold", 64'(in_ready), 64'(0));
          check("result", 64'(result), 64'(sb[0].res));
          check("eq_flag", 64'(eq_flag), 64'(sb[0].eq));
          check("gt_flag", 64'(gt_flag), 64'(sb[0].gt));
          if (out_ready) begin
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        if (alu_signal == 5'd5) begin
          m_eq = (op_a == op_b);
          m_gt = ($signed(op_a) > $signed(op_b));
        end
        e.res = model(alu_signal, op_a, op_b);
        e.eq  = m_eq;
        e.gt  = m_gt;
        e.acc = cyc;
        e.lat = ((alu_signal == 5'd3 || alu_signal == 5'd4) && op_b != '0) ? int'(W) + 1 : 1;
        sb.push_back(e);
      end
    end
  end

  // Present one op right after a rising edge and hold it until accepted.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    alu_signal = op;
    op_a = a;
    op_b = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst = 1'b1;
    in_valid = 1'b0;
    alu_signal = '0;
    op_a = '0;
    op_b = '0;
    out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_eq", 64'(eq_flag), 64'(0));
    check("rst_gt", 64'(gt_flag), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // add then asr back-to-back
    issue(5'd0, 32'd7, -32'sd3);
    issue(5'd12, 32'h8000_0000, 32'd4);
    drain();

    // compares and flag persistence
    issue(5'd5, 32'd5, 32'd5);
    issue(5'd5, -32'sd1, 32'd1);
    issue(5'd5, 32'd1, -32'sd1);
    issue(5'd0, 32'd2, 32'd3);
    drain();

    // reset in the middle of a divide
    issue(5'd3, 32'd100, 32'd3);
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_eq", 64'(eq_flag), 64'(0));
    check("abort_gt", 64'(gt_flag), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // iterative divide and modulo
    issue(5'd3, -32'sd7, 32'd2);
    issue(5'd4, -32'sd7, 32'd2);
    drain();

    // divide by zero and signed overflow
    issue(5'd3, 32'd5, 32'd0);
    issue(5'd4, 32'd5, 32'd0);
    issue(5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    // consumer stall with a competing input held
    out_ready = 1'b0;
    issue(5'd10, 32'd1, 32'd31);
    in_valid = 1'b1;
    alu_signal = 5'd0;
    op_a = 32'd1;
    op_b = 32'd1;
    tick(3);
    out_ready = 1'b1;
    issue(5'd0, 32'd1, 32'd1);
    drain();

    // random mix, including all opcodes and small signed divisors
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = W'($urandom());
      if ($urandom_range(0, 2) == 0) b = W'($signed(32'($urandom_range(0, 8))) - 32'sd4);
      else b = W'($urandom());
      issue(op, a, b);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
